// File: rtl/spi_poll_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the SPI poll master.
package spi_poll_pkg;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_LEV   = 2'b01;
    localparam logic [1:0] CODE_STAGE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    // Bits needed for a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Busy cycles for one full round: two slaves of SETUP + SHIFT + HOLD + GAP.
    function automatic int unsigned round_cycles(input int unsigned clk_div,
                                                 input int unsigned data_width);
        return 2 * (3 + 2 * data_width) * clk_div;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One mode-0 SPI byte transfer: a setup half-period, then 2*DATA_WIDTH SCLK half-periods.
module spi_byte_shifter
    import spi_poll_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  done
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);
    localparam int unsigned HP_W  = cnt_width(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_WIDTH);

    logic                  active_q, active_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [HP_W-1:0]       hp_q, hp_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  hp_end;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        hp_d     = hp_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        hp_end   = active_q && (div_q == DIV_LAST);
        done     = hp_end && (hp_q == HP_LAST);
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            hp_d     = '0;
            sclk_d   = 1'b0;
            mosi_d   = tx_byte[DATA_WIDTH-1];
            tx_d     = {tx_byte[DATA_WIDTH-2:0], 1'b0};
            rx_d     = '0;
        end else if (active_q) begin
            if (hp_end) begin
                div_d = '0;
                hp_d  = hp_q + HP_W'(1);
                // Half-period 0 is the setup window; odd ends rise, even ends fall.
                if (hp_q != '0) begin
                    if (hp_q[0]) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_WIDTH-2:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                if (done) begin
                    active_d = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            hp_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            hp_q     <= hp_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_poll_master.sv
// Periodic SPI master polling the level then stage sensor and driving SPI_Code for the decoder.
module spi_poll_master
    import spi_poll_pkg::*;
#(
    parameter int unsigned          CODE_SIZE   = 2,
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          CLK_DIV     = 4,
    parameter int unsigned          POLL_PERIOD = 1000,
    parameter logic [DATA_WIDTH-1:0] READ_CMD   = 'h01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [CODE_SIZE-1:0]  SPI_Code,
    output logic [DATA_WIDTH-1:0] lev_data,
    output logic [DATA_WIDTH-1:0] stage_data,
    output logic                  lev_valid,
    output logic                  stage_valid,
    output logic                  busy
);

    localparam int unsigned WAIT_W = cnt_width(POLL_PERIOD);
    localparam int unsigned PH_W   = cnt_width(CLK_DIV);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);

    state_e                state_q, state_d;
    logic                  slave_q, slave_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [CODE_SIZE-1:0]  code_q, code_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] lev_data_q, lev_data_d;
    logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
    logic                  lev_valid_q, lev_valid_d;
    logic                  stage_valid_q, stage_valid_d;
    logic                  start;
    logic                  capture;
    logic                  sh_done;
    logic [DATA_WIDTH-1:0] rx_byte;

    spi_byte_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_byte (READ_CMD),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_byte (rx_byte),
        .done    (sh_done)
    );

    always_comb begin
        state_d = state_q;
        slave_d = slave_q;
        wait_d  = wait_q;
        ph_d    = ph_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!en) begin
                    wait_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    slave_d = 1'b0;
                    state_d = ST_SETUP;
                    start   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SETUP: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = ST_SHIFT;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = ST_GAP;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_GAP: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (!slave_q) begin
                        slave_d = 1'b1;
                        state_d = ST_SETUP;
                        start   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so the registers line up with state_q.
        code_d = CODE_SIZE'(CODE_NONE);
        if (state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD) begin
            code_d = slave_d ? CODE_SIZE'(CODE_STAGE) : CODE_SIZE'(CODE_LEV);
        end
        busy_d        = (state_d != ST_IDLE);
        capture       = (state_q == ST_HOLD) && (state_d == ST_GAP);
        lev_valid_d   = capture && !slave_q;
        stage_valid_d = capture && slave_q;
        lev_data_d    = lev_valid_d ? rx_byte : lev_data_q;
        stage_data_d  = stage_valid_d ? rx_byte : stage_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slave_q       <= 1'b0;
            wait_q        <= '0;
            ph_q          <= '0;
            code_q        <= '0;
            busy_q        <= 1'b0;
            lev_data_q    <= '0;
            stage_data_q  <= '0;
            lev_valid_q   <= 1'b0;
            stage_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slave_q       <= slave_d;
            wait_q        <= wait_d;
            ph_q          <= ph_d;
            code_q        <= code_d;
            busy_q        <= busy_d;
            lev_data_q    <= lev_data_d;
            stage_data_q  <= stage_data_d;
            lev_valid_q   <= lev_valid_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    assign SPI_Code    = code_q;
    assign busy        = busy_q;
    assign lev_data    = lev_data_q;
    assign stage_data  = stage_data_q;
    assign lev_valid   = lev_valid_q;
    assign stage_valid = stage_valid_q;

endmodule

// File: tb/tb_spi_poll_master.sv
// Bench for spi_poll_master: behavioural SPI slave, bus monitor and per-scenario checks.
module tb_spi_poll_master;

    localparam int C   = 2;
    localparam int P   = 20;
    localparam int DW  = 8;
    localparam logic [7:0] CMD = 8'hA5;
    localparam int SLAVE_LEN = C + 2 * DW * C + C + C;
    localparam int ROUND_LEN = 2 * SLAVE_LEN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       miso = 1'b0;
    logic       sclk, mosi, lev_valid, stage_valid, busy;
    logic [1:0] SPI_Code;
    logic [7:0] lev_data, stage_data;

    int vec = 0;
    int err = 0;
    int cyc = 0;

    spi_poll_master #(
        .CODE_SIZE   (2),
        .DATA_WIDTH  (DW),
        .CLK_DIV     (C),
        .POLL_PERIOD (P),
        .READ_CMD    (CMD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .miso        (miso),
        .sclk        (sclk),
        .mosi        (mosi),
        .SPI_Code    (SPI_Code),
        .lev_data    (lev_data),
        .stage_data  (stage_data),
        .lev_valid   (lev_valid),
        .stage_valid (stage_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: bytes each slave will return, plus what the bench expects to receive.
    logic [7:0] lev_q[$];
    logic [7:0] stage_q[$];
    logic [7:0] exp_lev[$];
    logic [7:0] exp_stage[$];

    initial begin : slave_model
        logic [7:0] sl_byte;
        int         sl_bit;
        logic [1:0] sl_prev_code;
        logic       sl_prev_sclk;
        sl_byte = 8'h00;
        sl_bit = 8;
        sl_prev_code = 2'b00;
        sl_prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (SPI_Code == 2'b01 && sl_prev_code != 2'b01) begin
                sl_byte = 8'h00;
                if (lev_q.size() > 0) sl_byte = lev_q.pop_front();
                sl_bit = 0;
            end else if (SPI_Code == 2'b10 && sl_prev_code != 2'b10) begin
                sl_byte = 8'h00;
                if (stage_q.size() > 0) sl_byte = stage_q.pop_front();
                sl_bit = 0;
            end else if (sl_prev_sclk && !sclk) begin
                sl_bit++;
            end
            miso = (sl_bit < 8) ? sl_byte[7 - sl_bit] : 1'b0;
            sl_prev_code = SPI_Code;
            sl_prev_sclk = sclk;
        end
    end

    // Bus monitor: records what happened on the interface, sampled on falling clk edges.
    logic [1:0] code_seq[$];
    logic [7:0] mosi_win[$];
    int         rise_win[$];
    int         start_q[$];
    int         busy_len_q[$];
    logic [7:0] lev_obs[$];
    logic [7:0] stage_obs[$];
    int         bad11, sclk_bad, setup_bad, hold_bad;

    initial begin : monitor
        logic [1:0] prev_code;
        logic       prev_sclk, prev_busy;
        logic [7:0] cur_mosi;
        int         cur_rises, chg_cyc, fall_cyc, busy_run;
        prev_code = 2'b00; prev_sclk = 1'b0; prev_busy = 1'b0;
        cur_mosi = 8'h00; cur_rises = 0; chg_cyc = 0; fall_cyc = -1000; busy_run = 0;
        forever begin
            @(negedge clk);
            if (SPI_Code == 2'b11) bad11++;
            if (sclk && SPI_Code == 2'b00) sclk_bad++;
            if (SPI_Code != prev_code) begin
                if (prev_code != 2'b00) begin
                    if (cyc - fall_cyc < C) hold_bad++;
                    mosi_win.push_back(cur_mosi);
                    rise_win.push_back(cur_rises);
                end
                code_seq.push_back(SPI_Code);
                chg_cyc = cyc;
                cur_mosi = 8'h00;
                cur_rises = 0;
            end
            if (sclk && !prev_sclk) begin
                if (cur_rises == 0 && cyc - chg_cyc < C) setup_bad++;
                cur_mosi = {cur_mosi[6:0], mosi};
                cur_rises++;
            end
            if (!sclk && prev_sclk) fall_cyc = cyc;
            if (busy && !prev_busy) begin
                start_q.push_back(cyc);
                busy_run = 0;
            end
            if (busy) busy_run++;
            if (!busy && prev_busy) busy_len_q.push_back(busy_run);
            if (lev_valid) lev_obs.push_back(lev_data);
            if (stage_valid) stage_obs.push_back(stage_data);
            prev_code = SPI_Code;
            prev_sclk = sclk;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        code_seq.delete(); mosi_win.delete(); rise_win.delete();
        start_q.delete(); busy_len_q.delete(); lev_obs.delete(); stage_obs.delete();
        lev_q.delete(); stage_q.delete(); exp_lev.delete(); exp_stage.delete();
        bad11 = 0; sclk_bad = 0; setup_bad = 0; hold_bad = 0;
    endtask

    task automatic push_bytes(input logic [7:0] lb, input logic [7:0] sb);
        lev_q.push_back(lb); exp_lev.push_back(lb);
        stage_q.push_back(sb); exp_stage.push_back(sb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        tick(3);
        vec++;
        if ({SPI_Code, sclk, mosi, busy, lev_valid, stage_valid} !== 7'b0) begin
            err++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {SPI_Code, sclk, mosi, busy, lev_valid, stage_valid});
        end
        vec++;
        if ({lev_data, stage_data} !== 16'h0000) begin
            err++;
            $display("FAIL reset_data got=%h want=0000", {lev_data, stage_data});
        end
        rst_n = 1'b1;
        tick(2);
        clear_all();
    endtask

    task automatic test_idle_disabled();
        en = 1'b0;
        tick(300);
        vec++;
        if (start_q.size() != 0 || code_seq.size() != 0) begin
            err++;
            $display("FAIL idle_disabled rounds=%0d code_changes=%0d want=0,0",
                     start_q.size(), code_seq.size());
        end
        vec++;
        if (SPI_Code !== 2'b00) begin
            err++;
            $display("FAIL idle_code got=%b want=00", SPI_Code);
        end
    endtask

    task automatic test_basic_round();
        int t0, n;
        logic [1:0] want_seq[4];
        want_seq = '{2'b01, 2'b00, 2'b10, 2'b00};
        clear_all();
        push_bytes(8'h3C, 8'hC5);
        en = 1'b1;
        t0 = cyc;
        n = 0;
        while (busy_len_q.size() == 0 && n < 400) begin tick(1); n++; end
        en = 1'b0;
        tick(4);
        vec++;
        if (busy_len_q.size() != 1 || start_q.size() != 1) begin
            err++;
            $display("FAIL basic_complete rounds_done=%0d want=1", busy_len_q.size());
            return;
        end
        vec++;
        if (start_q[0] - t0 != P) begin
            err++;
            $display("FAIL first_start delay=%0d want=%0d", start_q[0] - t0, P);
        end
        vec++;
        if (busy_len_q[0] != ROUND_LEN) begin
            err++;
            $display("FAIL round_len got=%0d want=%0d", busy_len_q[0], ROUND_LEN);
        end
        vec++;
        if (code_seq.size() != 4) begin
            err++;
            $display("FAIL code_seq_len got=%0d want=4", code_seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (code_seq[i] !== want_seq[i]) begin
                    err++;
                    $display("FAIL code_seq[%0d] got=%b want=%b", i, code_seq[i], want_seq[i]);
                end
            end
        end
        vec++;
        if (lev_obs.size() != 1 || lev_obs[0] !== 8'h3C) begin
            err++;
            $display("FAIL lev_strobe pulses=%0d first=%h want=1 pulse of 3c",
                     lev_obs.size(), (lev_obs.size() > 0) ? lev_obs[0] : 8'hxx);
        end
        vec++;
        if (stage_obs.size() != 1 || stage_obs[0] !== 8'hC5) begin
            err++;
            $display("FAIL stage_strobe pulses=%0d first=%h want=1 pulse of c5",
                     stage_obs.size(), (stage_obs.size() > 0) ? stage_obs[0] : 8'hxx);
        end
        vec++;
        if (lev_data !== 8'h3C || stage_data !== 8'hC5) begin
            err++;
            $display("FAIL data_held lev=%h stage=%h want=3c c5", lev_data, stage_data);
        end
        test_mosi_sclk_windows(2);
    endtask

    // Evaluates the windows recorded by the round(s) just run.
    task automatic test_mosi_sclk_windows(input int nwin);
        vec++;
        if (mosi_win.size() != nwin) begin
            err++;
            $display("FAIL windows got=%0d want=%0d", mosi_win.size(), nwin);
        end else begin
            for (int i = 0; i < nwin; i++) begin
                vec++;
                if (mosi_win[i] !== CMD || rise_win[i] != DW) begin
                    err++;
                    $display("FAIL mosi_win[%0d] bits=%b rises=%0d want=%b %0d",
                             i, mosi_win[i], rise_win[i], CMD, DW);
                end
            end
        end
        vec++;
        if (bad11 != 0 || sclk_bad != 0 || setup_bad != 0 || hold_bad != 0) begin
            err++;
            $display("FAIL bus_rules code11=%0d sclk_unsel=%0d setup=%0d hold=%0d want=0",
                     bad11, sclk_bad, setup_bad, hold_bad);
        end
    endtask

    task automatic test_periodicity();
        int n;
        clear_all();
        for (int i = 0; i < 3; i++) push_bytes(8'($urandom), 8'($urandom));
        en = 1'b1;
        n = 0;
        while (busy_len_q.size() < 3 && n < 1000) begin tick(1); n++; end
        en = 1'b0;
        tick(4);
        vec++;
        if (busy_len_q.size() != 3) begin
            err++;
            $display("FAIL period_rounds got=%0d want=3", busy_len_q.size());
            return;
        end
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (busy_len_q[i] != ROUND_LEN) begin
                err++;
                $display("FAIL period_busy[%0d] got=%0d want=%0d", i, busy_len_q[i], ROUND_LEN);
            end
        end
        for (int i = 1; i < 3; i++) begin
            vec++;
            if (start_q[i] - start_q[i-1] != P + ROUND_LEN) begin
                err++;
                $display("FAIL period_gap[%0d] got=%0d want=%0d",
                         i, start_q[i] - start_q[i-1], P + ROUND_LEN);
            end
        end
        vec++;
        if (lev_obs.size() != 3 || stage_obs.size() != 3) begin
            err++;
            $display("FAIL period_strobes lev=%0d stage=%0d want=3,3",
                     lev_obs.size(), stage_obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vec++;
                if (lev_obs[i] !== exp_lev[i] || stage_obs[i] !== exp_stage[i]) begin
                    err++;
                    $display("FAIL period_data[%0d] lev=%h stage=%h want=%h %h",
                             i, lev_obs[i], stage_obs[i], exp_lev[i], exp_stage[i]);
                end
            end
        end
        test_mosi_sclk_windows(6);
    endtask

    task automatic test_en_drop();
        int n;
        clear_all();
        push_bytes(8'($urandom), 8'($urandom));
        en = 1'b1;
        n = 0;
        while (SPI_Code !== 2'b01 && n < 200) begin tick(1); n++; end
        vec++;
        if (SPI_Code !== 2'b01) begin
            err++;
            $display("FAIL en_drop_start code=%b want=01", SPI_Code);
        end
        tick(5);
        en = 1'b0;
        tick(3 * (P + ROUND_LEN));
        vec++;
        if (stage_obs.size() != 1 || stage_obs[0] !== exp_stage[0]) begin
            err++;
            $display("FAIL en_drop_stage pulses=%0d data=%h want=1 pulse of %h",
                     stage_obs.size(), (stage_obs.size() > 0) ? stage_obs[0] : 8'hxx, exp_stage[0]);
        end
        vec++;
        if (lev_obs.size() != 1 || lev_obs[0] !== exp_lev[0]) begin
            err++;
            $display("FAIL en_drop_lev pulses=%0d want=1 of %h", lev_obs.size(), exp_lev[0]);
        end
        vec++;
        if (start_q.size() != 1 || busy_len_q.size() != 1) begin
            err++;
            $display("FAIL en_drop_rounds starts=%0d ends=%0d want=1,1",
                     start_q.size(), busy_len_q.size());
        end else begin
            vec++;
            if (busy_len_q[0] != ROUND_LEN) begin
                err++;
                $display("FAIL en_drop_len got=%0d want=%0d", busy_len_q[0], ROUND_LEN);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        clear_all();
        push_bytes(8'($urandom), 8'($urandom));
        en = 1'b1;
        n = 0;
        while (!(SPI_Code === 2'b01 && sclk === 1'b1) && n < 200) begin tick(1); n++; end
        vec++;
        if (sclk !== 1'b1) begin
            err++;
            $display("FAIL mid_shift_reach sclk=%b want=1", sclk);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if ({SPI_Code, sclk, mosi, busy, lev_valid, stage_valid} !== 7'b0) begin
            err++;
            $display("FAIL mid_shift_reset got=%b want=0000000",
                     {SPI_Code, sclk, mosi, busy, lev_valid, stage_valid});
        end
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_all();
        tick(200);
        vec++;
        if (lev_obs.size() != 0 || stage_obs.size() != 0 || start_q.size() != 0) begin
            err++;
            $display("FAIL abort_no_strobe lev=%0d stage=%0d rounds=%0d want=0",
                     lev_obs.size(), stage_obs.size(), start_q.size());
        end
        vec++;
        if ({lev_data, stage_data} !== 16'h0000) begin
            err++;
            $display("FAIL abort_data got=%h want=0000", {lev_data, stage_data});
        end
    endtask

    initial begin
        test_reset();
        test_idle_disabled();
        test_basic_round();
        test_periodicity();
        test_en_drop();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_poll_master.md
# spi_poll_master

Periodic SPI master that polls the two post-op sensor slaves (level, then stage) in a fixed round and produces the 2-bit `SPI_Code` consumed by the slave-select decoder directly downstream. It generates SCLK/MOSI, samples MISO, and presents each slave's byte as registered data with a one-cycle valid strobe for the monitoring logic.

## Interface
- `CODE_SIZE`, 2: width of `SPI_Code`.
- `DATA_WIDTH`, 8: bits per transfer.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period (≥1).
- `POLL_PERIOD`, 1000: idle `clk` cycles between rounds (≥1).
- `READ_CMD`, 8'h01: byte shifted out on MOSI in every transfer.

Ports:
- `clk` in 1: single clock; all logic is clocked on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: enables polling.
- `miso` in 1: serial data from the selected slave.
- `sclk` out 1: SPI clock, mode 0 (idles low).
- `mosi` out 1: serial command, MSB first.
- `SPI_Code` out CODE_SIZE: 00 none, 01 level, 10 stage; feeds the decoder.
- `lev_data` out DATA_WIDTH: last level byte.
- `stage_data` out DATA_WIDTH: last stage byte.
- `lev_valid` out 1: one-cycle strobe, `lev_data` updated.
- `stage_valid` out 1: one-cycle strobe, `stage_data` updated.
- `busy` out 1: high from round start to round end.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A `slave` bit selects level (0) or stage (1).
- IDLE: the wait counter counts while `en`=1 and clears while `en`=0. At count POLL_PERIOD-1: clear the counter, set `slave`=0, go to SETUP.
- SETUP (CLK_DIV cycles):
  - `SPI_Code` = 01 or 10 according to `slave`.
  - `sclk`=0.
  - Load the shift register with READ_CMD.
  - `mosi` = READ_CMD MSB.
- SHIFT (2·DATA_WIDTH half-periods of CLK_DIV cycles each):
  - `sclk` toggles at the end of each half-period.
  - On each rising edge, MISO is shifted into the LSB.
  - On each falling edge, `mosi` advances to the next bit.
  - `sclk` is low on exit.
- HOLD (CLK_DIV cycles): `SPI_Code` held; `sclk`=0.
- GAP (CLK_DIV cycles):
  - `SPI_Code`=00.
  - On the first GAP cycle, the received byte loads into `lev_data` or `stage_data` and the matching valid is high for exactly that cycle.
  - At the end of GAP: if `slave`=0, set `slave`=1 and go to SETUP; otherwise go to IDLE.
- `en` falling mid-round: the round completes, then the FSM stays in IDLE.
- `SPI_Code`=11 is never driven.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values (asynchronous, immediate, including mid-transfer):
  - `SPI_Code`=00, `sclk`=0, `mosi`=0.
  - `lev_data`=`stage_data`=0.
  - Both valids 0; `busy`=0.
  - FSM in IDLE; counters 0.
  - No valid strobe for an aborted transfer.
- All outputs are registered; no combinational path from `miso` or `en` to any output.
- Per slave: SETUP CLK_DIV + SHIFT 2·DATA_WIDTH·CLK_DIV + HOLD CLK_DIV + GAP CLK_DIV = 19·CLK_DIV cycles at defaults.
- Full round: 38·CLK_DIV cycles. Round start-to-start: POLL_PERIOD + 38·CLK_DIV.
- First round starts POLL_PERIOD cycles after `en` rises (or after reset release with `en`=1).
- Setup and hold: `SPI_Code` is stable CLK_DIV cycles before the first SCLK edge and CLK_DIV cycles after the last one.
- MISO is sampled on the `clk` edge that drives `sclk` high.

## Structure
- Package `spi_poll_pkg` holds:
  - Code constants `CODE_NONE`=2'b00, `CODE_LEV`=2'b01, `CODE_STAGE`=2'b10.
  - The FSM state encoding.
  - The helper function for round length.
- Sub-module `spi_byte_shifter` owns the half-period divider, bit counter, and shift register:
  - Inputs: `start`, `tx_byte`.
  - Outputs: `sclk`, `mosi`, `rx_byte`, `done` pulse.
  - The top FSM handles sequencing and `SPI_Code`.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-SHIFT → all outputs at reset values on the same cycle; with `en`=0 the block stays idle indefinitely and `SPI_Code`=00.
- Basic round (CLK_DIV=2, POLL_PERIOD=20; slave model returns 8'h3C for level, 8'hC5 for stage):
  - `SPI_Code` sequence is 01, 00, 10, 00.
  - `lev_data`=8'h3C with a one-cycle `lev_valid`; `stage_data`=8'hC5 with a one-cycle `stage_valid`.
  - Round length is 76 cycles.
- MOSI/SCLK: with READ_CMD=8'hA5, `mosi` sampled on rising edges reads 1010_0101; exactly 8 rising edges per select window; `sclk` is low whenever `SPI_Code`=00.
- Periodicity: with `en` held high, round starts are 96 cycles apart (CLK_DIV=2, POLL_PERIOD=20); `busy` is high for exactly 76 cycles of each.
- `en` dropped during the level transfer → the stage transfer still completes and `stage_valid` fires, then no further rounds occur.
- Setup/hold check: `SPI_Code` is stable at least CLK_DIV cycles before the first `sclk` rise and after the last `sclk` fall; `SPI_Code`=11 never appears.
